// File: rtl/gate_frame_if.sv
// Bundle between the frame dispatcher and its environment: the SPI frame
// receiver, the per-module UART TX/RX pairs and the shoot/status outputs.
interface gate_frame_if #(
  parameter int N_CH   = 9,
  parameter int DATA_W = 8
);
  logic                     frame_valid;
  logic                     frame_ready;
  logic [N_CH*DATA_W-1:0]   frame_data;
  logic                     debug_mode;
  logic [N_CH-1:0]          start_tx;
  logic [N_CH*DATA_W-1:0]   data_to_tx;
  logic [N_CH-1:0]          tx_busy;
  logic [N_CH-1:0]          rx_done;
  logic [N_CH*DATA_W-1:0]   data_received;
  logic [N_CH-1:0]          parity_error;
  logic                     shoot;
  logic                     done;
  logic [N_CH-1:0]          ack_fail;
  logic                     timeout_err;
  logic [15:0]              frame_count;

  // Dispatcher side
  modport master (
    input  frame_valid, frame_data, debug_mode, tx_busy,
           rx_done, data_received, parity_error,
    output frame_ready, start_tx, data_to_tx, shoot, done,
           ack_fail, timeout_err, frame_count
  );

  // Environment side (frame source, UARTs, power stage)
  modport slave (
    output frame_valid, frame_data, debug_mode, tx_busy,
           rx_done, data_received, parity_error,
    input  frame_ready, start_tx, data_to_tx, shoot, done,
           ack_fail, timeout_err, frame_count
  );
endinterface

// File: rtl/gate_frame_dispatcher.sv
// Gate frame dispatcher: takes one switching frame (one word per power
// module), starts all UART TX links together, optionally checks the echo from
// every module, then fires one global shoot pulse so all modules switch at
// the same instant.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | frame_ready high, waiting for a frame
// LAUNCH   | start_tx all ones for one cycle
// WAIT_TX  | guard cycle, then wait for every tx_busy to drop
// WAIT_ACK | collect echoes; timeout down-counter running
// SHOOT    | shoot high for SHOOT_LEN cycles
// FINISH   | done high for one cycle, then back to IDLE
module gate_frame_dispatcher #(
  parameter int N_CH        = 9,
  parameter int DATA_W      = 8,
  parameter int SHOOT_LEN   = 4,
  parameter int ACK_EN      = 1,
  parameter int ACK_TIMEOUT = 48000
) (
  input  logic         clk,
  input  logic         reset,
  gate_frame_if.master bus
);

  // One down-counter serves both the ack timeout and the shoot width.
  localparam int CNT_MAX = (ACK_TIMEOUT > SHOOT_LEN) ? ACK_TIMEOUT : SHOOT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SH_LOAD = CNT_W'(SHOOT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [N_CH-1:0]  ALL_CH  = {N_CH{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_TX  = 3'd2,
    WAIT_ACK = 3'd3,
    SHOOT    = 3'd4,
    FINISH   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             guard;
  logic             dbg;
  logic [N_CH-1:0]  seen;

  logic [N_CH-1:0]  take;
  logic [N_CH-1:0]  bad;
  logic [N_CH-1:0]  seen_nx;
  logic [N_CH-1:0]  fail_nx;

  // Per-channel echo qualification: only the first rx_done of a channel
  // counts; a parity error or a word that differs from what was sent fails it.
  always_comb begin
    take = '0;
    bad  = '0;
    for (int i = 0; i < N_CH; i++) begin
      take[i] = bus.rx_done[i] & ~seen[i];
      bad[i]  = take[i] & (bus.parity_error[i] |
                (bus.data_received[i*DATA_W +: DATA_W] != bus.data_to_tx[i*DATA_W +: DATA_W]));
    end
    seen_nx = seen | take;
    fail_nx = bus.ack_fail | bad;
  end

  // Sequencer with registered outputs; reset discards any in-flight frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      guard           <= 1'b0;
      dbg             <= 1'b0;
      seen            <= '0;
      bus.frame_ready <= 1'b0;
      bus.start_tx    <= '0;
      bus.data_to_tx  <= '0;
      bus.shoot       <= 1'b0;
      bus.done        <= 1'b0;
      bus.ack_fail    <= '0;
      bus.timeout_err <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_valid && bus.frame_ready) begin
            bus.frame_ready <= 1'b0;
            bus.data_to_tx  <= bus.frame_data;
            dbg             <= bus.debug_mode;
            bus.ack_fail    <= '0;
            bus.timeout_err <= 1'b0;
            seen            <= '0;
            bus.start_tx    <= ALL_CH;
            state           <= LAUNCH;
          end else begin
            bus.frame_ready <= 1'b1;
          end
        end

        LAUNCH: begin
          bus.start_tx <= '0;
          guard        <= 1'b1;
          state        <= WAIT_TX;
        end

        WAIT_TX: begin
          // The UARTs raise busy one cycle after start, so the first cycle
          // here cannot be trusted.
          if (guard) begin
            guard <= 1'b0;
          end else if (bus.tx_busy == '0) begin
            if (ACK_EN != 0) begin
              cnt   <= TO_LOAD;
              state <= WAIT_ACK;
            end else if (dbg) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.shoot       <= 1'b1;
              bus.frame_count <= bus.frame_count + 16'd1;
              cnt             <= SH_LOAD;
              state           <= SHOOT;
            end
          end
        end

        WAIT_ACK: begin
          seen         <= seen_nx;
          bus.ack_fail <= fail_nx;
          // A complete echo set takes priority over a timeout in the same cycle.
          if (seen_nx == ALL_CH) begin
            if ((fail_nx != '0) || dbg) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.shoot       <= 1'b1;
              bus.frame_count <= bus.frame_count + 16'd1;
              cnt             <= SH_LOAD;
              state           <= SHOOT;
            end
          end else if (cnt == '0) begin
            bus.timeout_err <= 1'b1;
            bus.ack_fail    <= fail_nx | ~seen_nx;
            bus.done        <= 1'b1;
            state           <= FINISH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        SHOOT: begin
          if (cnt == '0) begin
            bus.shoot <= 1'b0;
            bus.done  <= 1'b1;
            state     <= FINISH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        FINISH: begin
          bus.done        <= 1'b0;
          bus.frame_ready <= 1'b1;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_frame_dispatcher.sv
// Directed bench for gate_frame_dispatcher. Two instances: dut0 runs without
// ack checking, dut1 with ack checking and a short (100 cycle) timeout.
// A simple UART TX model keeps busy high for 10 cycles after each start.
module tb_gate_frame_dispatcher;

  localparam int NC = 9;
  localparam int DW = 8;

  logic clk;
  logic rst0;
  logic rst1;

  gate_frame_if #(.N_CH(NC), .DATA_W(DW)) if0 ();
  gate_frame_if #(.N_CH(NC), .DATA_W(DW)) if1 ();

  gate_frame_dispatcher #(
    .N_CH(NC), .DATA_W(DW), .SHOOT_LEN(4), .ACK_EN(0), .ACK_TIMEOUT(100)
  ) dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (if0)
  );

  gate_frame_dispatcher #(
    .N_CH(NC), .DATA_W(DW), .SHOOT_LEN(4), .ACK_EN(1), .ACK_TIMEOUT(100)
  ) dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int busy0 [NC];
  int busy1 [NC];

  // UART TX model: busy for 10 cycles after the cycle start_tx is seen.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (if0.start_tx[i]) busy0[i] <= 10;
      else if (busy0[i] != 0) busy0[i] <= busy0[i] - 1;
      if (if1.start_tx[i]) busy1[i] <= 10;
      else if (busy1[i] != 0) busy1[i] <= busy1[i] - 1;
    end
  end

  // Busy flags derived from the TX model counters.
  always_comb begin
    if0.tx_busy = '0;
    if1.tx_busy = '0;
    for (int i = 0; i < NC; i++) begin
      if0.tx_busy[i] = (busy0[i] != 0);
      if1.tx_busy[i] = (busy1[i] != 0);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_echo(input int ch, input logic [7:0] w, input logic p);
    if1.rx_done[ch]             = 1'b1;
    if1.data_received[ch*8 +: 8] = w;
    if1.parity_error[ch]        = p;
  endtask

  task automatic clr_echo();
    if1.rx_done      = '0;
    if1.parity_error = '0;
  endtask

  logic [71:0] frm;
  logic [71:0] frm2;
  int          n;
  int          early;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) frm[i*8 +: 8] = 8'(i + 1);
    frm2 = ~frm;

    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.frame_valid = 1'b0; if0.frame_data = '0; if0.debug_mode = 1'b0;
    if0.rx_done = '0; if0.data_received = '0; if0.parity_error = '0;
    if1.frame_valid = 1'b0; if1.frame_data = '0; if1.debug_mode = 1'b0;
    if1.rx_done = '0; if1.data_received = '0; if1.parity_error = '0;

    repeat (3) tick();
    chk("rst_ready",     if0.frame_ready, 0);
    chk("rst_start_tx",  if0.start_tx, 0);
    chk("rst_data",      if0.data_to_tx, 0);
    chk("rst_shoot",     if0.shoot, 0);
    chk("rst_done",      if0.done, 0);
    chk("rst_count",     if0.frame_count, 0);
    chk("rst_ack_fail",  if1.ack_fail, 0);
    chk("rst_timeout",   if1.timeout_err, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick();
    chk("ready_after_rst0", if0.frame_ready, 1);
    chk("ready_after_rst1", if1.frame_ready, 1);

    // T1: no-ack broadcast
    if0.frame_data = frm; if0.debug_mode = 1'b0; if0.frame_valid = 1'b1;
    tick();                                   // cycle 0 (LAUNCH)
    if0.frame_valid = 1'b0;
    chk("t1_start_tx", if0.start_tx, 9'h1FF);
    chk("t1_data",     if0.data_to_tx, frm);
    chk("t1_ready_lo", if0.frame_ready, 0);
    tick();                                   // cycle 1
    chk("t1_start_once", if0.start_tx, 0);
    repeat (10) tick();                       // cycle 11
    chk("t1_no_early_shoot", if0.shoot, 0);
    n = 0;
    repeat (4) begin tick(); if (if0.shoot === 1'b1) n++; end   // cycles 12..15
    chk("t1_count", if0.frame_count, 1);
    tick();                                   // cycle 16
    chk("t1_shoot_len", n, 4);
    chk("t1_shoot_off", if0.shoot, 0);
    chk("t1_done",      if0.done, 1);
    tick();                                   // cycle 17
    chk("t1_done_once", if0.done, 0);
    chk("t1_ready_hi",  if0.frame_ready, 1);

    // T2: staggered correct echoes, plus ignored stray/repeat rx_done
    if1.frame_data = frm; if1.debug_mode = 1'b0; if1.frame_valid = 1'b1;
    tick();                                   // cycle 0
    if1.frame_valid = 1'b0;
    early = 0;
    for (int c = 1; c <= 37; c++) begin
      tick();
      clr_echo();
      if (c == 5) set_echo(8, 8'h00, 1'b0);
      if (c >= 13 && ((c - 13) % 3) == 0) set_echo((c - 13) / 3, frm[((c - 13) / 3)*8 +: 8], 1'b0);
      if (c == 20) set_echo(0, 8'hEE, 1'b0);
      if (if1.shoot === 1'b1) early++;
    end
    tick();                                   // cycle 38
    clr_echo();
    chk("t2_no_early_shoot", early, 0);
    chk("t2_shoot",    if1.shoot, 1);
    chk("t2_count",    if1.frame_count, 1);
    chk("t2_ack_fail", if1.ack_fail, 0);
    repeat (4) tick();                        // cycle 42
    chk("t2_done",     if1.done, 1);
    chk("t2_shoot_off", if1.shoot, 0);
    tick();

    // T3: channel 3 echoes 0xFF
    if1.frame_valid = 1'b1;
    tick();
    if1.frame_valid = 1'b0;
    repeat (12) tick();                       // cycle 12
    for (int i = 0; i < NC; i++) set_echo(i, (i == 3) ? 8'hFF : frm[i*8 +: 8], 1'b0);
    tick();                                   // cycle 13
    clr_echo();
    chk("t3_ack_fail", if1.ack_fail, 9'h008);
    chk("t3_done",     if1.done, 1);
    chk("t3_no_shoot", if1.shoot, 0);
    chk("t3_count",    if1.frame_count, 1);
    chk("t3_timeout",  if1.timeout_err, 0);
    tick();
    chk("t3_sticky",   if1.ack_fail, 9'h008);

    // T3b: channel 5 correct word with parity error
    if1.frame_valid = 1'b1;
    tick();
    if1.frame_valid = 1'b0;
    chk("t3b_cleared", if1.ack_fail, 0);
    repeat (12) tick();
    for (int i = 0; i < NC; i++) set_echo(i, frm[i*8 +: 8], (i == 5) ? 1'b1 : 1'b0);
    tick();
    clr_echo();
    chk("t3b_ack_fail", if1.ack_fail, 9'h020);
    chk("t3b_no_shoot", if1.shoot, 0);
    tick();

    // T4: channel 7 silent -> timeout 100 cycles into WAIT_ACK
    if1.frame_valid = 1'b1;
    tick();
    if1.frame_valid = 1'b0;
    repeat (12) tick();                       // cycle 12, first WAIT_ACK cycle
    for (int i = 0; i < NC; i++) if (i != 7) set_echo(i, frm[i*8 +: 8], 1'b0);
    tick();
    clr_echo();
    repeat (98) tick();                       // cycle 111
    chk("t4_before_to", if1.timeout_err, 0);
    chk("t4_before_done", if1.done, 0);
    tick();                                   // cycle 112
    chk("t4_timeout",  if1.timeout_err, 1);
    chk("t4_ack_fail", if1.ack_fail, 9'h080);
    chk("t4_done",     if1.done, 1);
    chk("t4_no_shoot", if1.shoot, 0);
    tick();
    chk("t4_sticky",   if1.timeout_err, 1);
    chk("t4_ready",    if1.frame_ready, 1);

    // T5: debug frame, valid held high, second (normal) frame follows
    if1.frame_data = frm; if1.debug_mode = 1'b1; if1.frame_valid = 1'b1;
    tick();                                   // cycle 0
    chk("t5_to_cleared", if1.timeout_err, 0);
    chk("t5_af_cleared", if1.ack_fail, 0);
    if1.frame_data = frm2; if1.debug_mode = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < NC; i++) set_echo(i, frm[i*8 +: 8], 1'b0);
    tick();                                   // cycle 13
    clr_echo();
    chk("t5_done",     if1.done, 1);
    chk("t5_no_shoot", if1.shoot, 0);
    chk("t5_count",    if1.frame_count, 1);
    chk("t5_ready_lo", if1.frame_ready, 0);
    tick();                                   // cycle 14
    chk("t5_ready_hi", if1.frame_ready, 1);
    chk("t5_no_start", if1.start_tx, 0);
    tick();                                   // second frame cycle 0
    if1.frame_valid = 1'b0;
    chk("t5_second_start", if1.start_tx, 9'h1FF);
    chk("t5_second_data",  if1.data_to_tx, frm2);
    repeat (12) tick();
    for (int i = 0; i < NC; i++) set_echo(i, frm2[i*8 +: 8], 1'b0);
    tick();
    clr_echo();
    chk("t5_second_shoot", if1.shoot, 1);
    chk("t5_second_count", if1.frame_count, 2);
    repeat (4) tick();
    chk("t5_second_done",  if1.done, 1);

    // T6: reset on second shoot cycle of dut0
    if0.frame_valid = 1'b1;
    tick();
    if0.frame_valid = 1'b0;
    repeat (13) tick();                       // cycle 13
    chk("t6_shoot_pre", if0.shoot, 1);
    chk("t6_count_pre", if0.frame_count, 2);
    rst0 = 1'b1;
    tick();                                   // cycle 14
    chk("t6_shoot_rst", if0.shoot, 0);
    chk("t6_ready_rst", if0.frame_ready, 0);
    chk("t6_count_rst", if0.frame_count, 0);
    chk("t6_data_rst",  if0.data_to_tx, 0);
    chk("t6_done_rst",  if0.done, 0);
    rst0 = 1'b0;
    tick();
    chk("t6_ready_after", if0.frame_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_frame_dispatcher.md
Name: gate_frame_dispatcher

Overview:
- Parametrised dispatcher between the SPI frame receiver and the per-module UART links of the inverter controller.
- Accepts one switching frame (one byte per power module) and launches every channel's UART TX in the same cycle.
- Optionally collects an echo acknowledge from each module, then issues a single global shoot pulse so all modules switch together.
- Generalises the fixed 9-UART broadcast: channel count, byte width, shoot length and ack timeout are parameters; adds ack checking, error reporting and a debug (no-shoot) mode.

Parameters:
- N_CH, 9, number of module channels (1..16)
- DATA_W, 8, bits per channel word
- SHOOT_LEN, 4, shoot pulse width in clk cycles (>=1)
- ACK_EN, 1, 1 = require an echo ack from every channel before shoot
- ACK_TIMEOUT, 48000, clk cycles allowed in WAIT_ACK (1 ms at 48 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_valid  in  1  frame_data is valid
- frame_ready  out  1  dispatcher can accept a frame
- frame_data  in  N_CH*DATA_W  channel i word at bits [i*DATA_W +: DATA_W]
- debug_mode  in  1  sampled at frame accept; 1 = suppress shoot
- start_tx  out  N_CH  one-cycle start strobe per UART TX
- data_to_tx  out  N_CH*DATA_W  latched word per channel
- tx_busy  in  N_CH  UART TX busy
- rx_done  in  N_CH  UART RX byte strobe
- data_received  in  N_CH*DATA_W  UART RX byte per channel
- parity_error  in  N_CH  qualifies rx_done
- shoot  out  1  global fire pulse
- done  out  1  one-cycle end-of-frame strobe
- ack_fail  out  N_CH  channels that failed ack in the last frame (sticky until the next accept)
- timeout_err  out  1  last frame ended by timeout (sticky until the next accept)
- frame_count  out  16  frames that completed with shoot (wraps at 0xFFFF -> 0)

Behaviour:
- Reset values: frame_ready=0, start_tx=0, data_to_tx=0, shoot=0, done=0, ack_fail=0, timeout_err=0, frame_count=0; state=IDLE. frame_ready goes high the first cycle after reset deasserts.
- Reset mid-operation (any state): all outputs take their reset values at that edge; shoot drops on the same edge; the in-flight frame is discarded.
- States: IDLE, LAUNCH, WAIT_TX, WAIT_ACK, SHOOT, FINISH.
- IDLE: frame_ready=1. When frame_valid&frame_ready: latch frame_data into data_to_tx, latch debug_mode, clear ack_fail/timeout_err/ack-seen vector -> LAUNCH. frame_ready is 0 in all other states.
- LAUNCH: start_tx = all ones for exactly one cycle -> WAIT_TX.
- WAIT_TX: first cycle is a guard cycle (tx_busy ignored; UART raises busy within one cycle of start). Afterwards wait until tx_busy == 0 on all channels. Then -> WAIT_ACK if ACK_EN, else -> SHOOT (or FINISH if debug).
- WAIT_ACK: timeout counter starts at 0.
  - Per channel i, an rx_done[i] with parity_error[i]=0 and data_received word == data_to_tx word sets seen[i].
  - An rx_done with a parity error or a mismatched word sets ack_fail[i] and seen[i].
  - Repeat rx_done on an already-seen channel is ignored.
  - rx_done in any other state is ignored.
  - When seen is all ones: any ack_fail -> FINISH without shoot; otherwise -> SHOOT (or FINISH if debug).
  - If the counter reaches ACK_TIMEOUT-1 without all seen: timeout_err=1, ack_fail |= ~seen, -> FINISH without shoot.
  - If all seen and timeout occur in the same cycle, seen wins (no timeout).
- SHOOT: shoot=1 for exactly SHOOT_LEN cycles; frame_count increments once on entry -> FINISH.
- FINISH: done=1 for one cycle -> IDLE. Minimum spacing between consecutive shoots is therefore the TX time + SHOOT_LEN + 3 cycles.
- debug_mode frames run the full TX/ack sequence but never assert shoot or increment frame_count.

Test Plan:
- N_CH=9, ACK_EN=0, frame 0x01..0x09, TX model busy 10 cycles -> start_tx=0x1FF for one cycle, data_to_tx matches; shoot high 4 cycles starting after the last busy falls; done one cycle later; frame_count=1.
- ACK_EN=1, all models echo correct bytes at staggered delays -> shoot once, after the last echo; ack_fail=0.
- Channel 3 echoes 0xFF instead of 0x04 -> ack_fail=0x008, no shoot, done pulses, frame_count unchanged.
- Channel 7 never echoes, ACK_TIMEOUT=100 -> timeout_err=1, ack_fail=0x080 exactly 100 cycles into WAIT_ACK; no shoot.
- debug_mode=1 with valid echoes -> shoot stays 0, done pulses, frame_count unchanged; frame_valid held high -> second frame accepted only after done.
- Reset asserted on the second SHOOT cycle -> shoot=0 and frame_ready=0 the next cycle; frame_ready=1 one cycle after reset deasserts; frame_count=0.
